pi_servo: RTL and testbench
===========================

# pi_servo

Proportional-integral loop filter that turns a stream of signed phase-error samples into the signed frequency correction `ACTION` consumed by the FTW tuning adder. It sits directly upstream of that adder: the adder sums `action` with the nominal FTW to produce the tuned FTW for the DDS. The block is a fixed 3-stage pipeline with a saturating integrator and a saturating output.

## Interface
- `ERR_W`, 16: error sample width, signed
- `GAIN_W`, 18: kp/ki width, signed
- `ACC_W`, 48: integrator width, signed
- `OUT_W`, 32: action width, signed; matches adder `ACTION`
- `SHIFT`, 16: arithmetic right shift applied before output saturation
- `clk`  in  1  sole clock
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  loop enable; low = loop open
- `err_valid`  in  1  one-cycle qualifier for `err`
- `err`  in  ERR_W  signed phase error
- `kp`, `ki`  in  GAIN_W  signed gains, sampled with each valid error
- `int_clear`  in  1  synchronous integrator clear
- `action`  out  OUT_W  signed correction, held between updates
- `action_valid`  out  1  one-cycle pulse per new `action`
- `sat`  out  1  the last output sample involved a clamp (integrator or output)

## Operation
- Reset: `action`=0, `action_valid`=0, `sat`=0, integrator=0, all pipeline valids 0.
- S1, when `en & err_valid`: `p_prod`=err·kp, `i_prod`=err·ki, each full signed ERR_W+GAIN_W bits; `v1`=1.
- S2, when `v1`: integrator ← clampACC(integrator + sext(`i_prod`)); `p_d` ← `p_prod`; `v2`=1. Record `isat` when the clamp engaged.
- S3, when `v2`: sum = sext(`p_d`) + integrator, ACC_W+1 bits; shifted = sum >>> SHIFT (floor, no rounding); `action` ← clampOUT(shifted); `action_valid`=1; `sat` ← `isat` | output clamp.
- Clamp ranges: [−2^(W−1), 2^(W−1)−1] for W=ACC_W and W=OUT_W. Never wraps.
- `int_clear`: integrator ← 0 that cycle. Wins over an S2 update in the same cycle; that sample's `i_prod` is discarded, its `p_d` still propagates.
- `en` low: integrator, `action`, `sat`, `v1`, `v2` are forced to 0 on the next edge; in-flight samples are dropped, no `action_valid`. The adder therefore sees zero correction.
- Gain changes take effect from the next valid sample and do not rescale the integrator.

## Timing
- Latency: `err_valid` at edge N gives `action_valid` high during cycle N+3.
- Throughput: one sample per clock; back-to-back valids are fully supported.
- `action` changes only on `action_valid` cycles, on `en` drop, or on reset.
- Reset mid-pipeline clears everything asynchronously; the first output after release requires a new `err_valid`.

## Configuration
- `PI_SERVO_HOLD_EN`: adds input port `hold` (1 bit). When it is high, S2 does not update the integrator (`int_clear` still applies) and S3 uses the frozen value, so only the P path acts. Use this during relock or cycle slips.
- Without the macro there is no `hold` port and the integrator always updates.

## Structure
- `pi_servo_pkg`: default widths and SHIFT, a `sat_t` flag type, min/max constant helpers for the ACC_W and OUT_W clamps.
- One sub-module, `sat_trunc`: parameterised signed saturating narrowing with a clamp flag, used for both the integrator and the output.

## Test plan
Defaults throughout.
- kp=65536, ki=0, single err=100 → `action`=100 with `action_valid` exactly 3 cycles later; `sat`=0.
- kp=0, ki=65536, err=1 on three consecutive cycles → `action` 1, 2, 3 on consecutive cycles.
- kp=1, ki=0, err=−1 → `action`=−1 (floor shift); err=+1 → `action`=0.
- kp=ki=131071, err=32767 held continuously → `action` clamps at 2147483647, `sat`=1, integrator stops at 2^47−1 with no wrap; then err=−32767 → `action` falls monotonically.
- Integrator at 5 (ki=65536), then `int_clear` on the same cycle a ki sample reaches S2 → integrator=0, that sample contributes only its P term.
- `en` dropped one cycle after `err_valid` → no `action_valid`, `action`=0, integrator=0. Also assert `rst` mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/pi_servo_pkg.sv
// pi_servo_pkg: shared constants and helpers for the PI loop filter.
//   DEF_*  : default widths and output shift of pi_servo
//   sat_t  : per-sample clamp flags (integrator clamp, output clamp)
//   smax/smin : largest / smallest value of a W-bit signed number
// Optional feature macro used by pi_servo: PI_SERVO_HOLD_EN.
package pi_servo_pkg;

  localparam int DEF_ERR_W  = 16;
  localparam int DEF_GAIN_W = 18;
  localparam int DEF_ACC_W  = 48;
  localparam int DEF_OUT_W  = 32;
  localparam int DEF_SHIFT  = 16;

  typedef struct packed {
    logic isat;  // integrator hit its rail on this sample
    logic osat;  // output narrowing clamped on this sample
  } sat_t;

  // Valid for 2 <= w <= 63.
  function automatic longint smax(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint smin(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/pi_servo_sat_trunc.sv
// sat_trunc: signed saturating narrowing from IN_W to OUT_W bits.
//   din     in  IN_W   signed value to narrow
//   dout    out OUT_W  din clamped into [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//   clamped out 1      din did not fit and was clamped
// Purely combinational; used for both the integrator and the output.
module sat_trunc
  import pi_servo_pkg::*;
#(
  parameter int IN_W  = 49,
  parameter int OUT_W = 48
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clamped
);

  localparam logic signed [OUT_W-1:0] MAXV = OUT_W'(smax(OUT_W));
  localparam logic signed [OUT_W-1:0] MINV = OUT_W'(smin(OUT_W));

  // The value fits exactly when every bit from the new sign bit upward
  // is a copy of the original sign bit.
  logic [IN_W-OUT_W:0] head;
  assign head = din[IN_W-1:OUT_W-1];

  always_comb begin
    dout    = din[OUT_W-1:0];
    clamped = 1'b0;
    if ((|head) && !(&head)) begin
      clamped = 1'b1;
      dout    = din[IN_W-1] ? MINV : MAXV;
    end
  end

endmodule

// File: rtl/pi_servo.sv
// pi_servo: 3-stage PI loop filter producing the signed frequency correction
// that is summed with the nominal FTW.
//   clk          in  1       sole clock
//   rst          in  1       asynchronous active-high reset
//   en           in  1       loop enable; low forces integrator/action to 0
//   err_valid    in  1       qualifier for err
//   err          in  ERR_W   signed phase error
//   kp, ki       in  GAIN_W  signed gains, sampled with each valid err
//   int_clear    in  1       synchronous integrator clear (beats an update)
//   hold         in  1       (only with PI_SERVO_HOLD_EN) freeze integrator
//   action       out OUT_W   signed correction, held between updates
//   action_valid out 1       one-cycle pulse per new action
//   sat          out 1       last output involved an integrator/output clamp
// Pipeline: S1 multiplies, S2 integrates, S3 sums, shifts and clamps.
module pi_servo
  import pi_servo_pkg::*;
#(
  parameter int ERR_W  = DEF_ERR_W,
  parameter int GAIN_W = DEF_GAIN_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     err_valid,
  input  logic signed [ERR_W-1:0]  err,
  input  logic signed [GAIN_W-1:0] kp,
  input  logic signed [GAIN_W-1:0] ki,
  input  logic                     int_clear,
`ifdef PI_SERVO_HOLD_EN
  input  logic                     hold,
`endif
  output logic signed [OUT_W-1:0]  action,
  output logic                     action_valid,
  output logic                     sat
);

  localparam int PROD_W = ERR_W + GAIN_W;
  localparam int SUM_W  = ACC_W + 1;

  logic signed [PROD_W-1:0] p_mul, i_mul;
  logic signed [PROD_W-1:0] p_prod, i_prod, p_d;
  logic                     v1, v2;
  logic signed [ACC_W-1:0]  integ, int_next;
  logic                     int_clamp, isat;
  logic signed [SUM_W-1:0]  int_sum, out_sum, out_shift;
  logic signed [OUT_W-1:0]  out_next;
  logic                     out_clamp;
  logic                     int_hold;
  sat_t                     flags;

`ifdef PI_SERVO_HOLD_EN
  assign int_hold = hold;
`else
  assign int_hold = 1'b0;
`endif

  // Operands are sign-extended to the full product width first so the
  // product is exact.
  assign p_mul = PROD_W'(err) * PROD_W'(kp);
  assign i_mul = PROD_W'(err) * PROD_W'(ki);

  // One guard bit above the integrator keeps both sums overflow-free.
  assign int_sum   = {{(SUM_W-PROD_W){i_prod[PROD_W-1]}}, i_prod}
                   + {integ[ACC_W-1], integ};
  assign out_sum   = {{(SUM_W-PROD_W){p_d[PROD_W-1]}}, p_d}
                   + {integ[ACC_W-1], integ};
  assign out_shift = out_sum >>> SHIFT;  // floor, no rounding

  sat_trunc #(.IN_W(SUM_W), .OUT_W(ACC_W)) u_int_sat (
    .din    (int_sum),
    .dout   (int_next),
    .clamped(int_clamp)
  );

  sat_trunc #(.IN_W(SUM_W), .OUT_W(OUT_W)) u_out_sat (
    .din    (out_shift),
    .dout   (out_next),
    .clamped(out_clamp)
  );

  assign flags = '{isat: isat, osat: out_clamp};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_prod       <= '0;
      i_prod       <= '0;
      p_d          <= '0;
      v1           <= 1'b0;
      v2           <= 1'b0;
      integ        <= '0;
      isat         <= 1'b0;
      action       <= '0;
      action_valid <= 1'b0;
      sat          <= 1'b0;
    end else if (!en) begin
      // Loop open: drop in-flight samples and present zero correction.
      v1           <= 1'b0;
      v2           <= 1'b0;
      integ        <= '0;
      isat         <= 1'b0;
      action       <= '0;
      action_valid <= 1'b0;
      sat          <= 1'b0;
    end else begin
      // S1
      v1 <= err_valid;
      if (err_valid) begin
        p_prod <= p_mul;
        i_prod <= i_mul;
      end

      // S2: a clear discards this sample's I term; its P term still flows.
      v2 <= v1;
      if (v1) begin
        p_d <= p_prod;
      end
      if (int_clear) begin
        integ <= '0;
        if (v1) isat <= 1'b0;
      end else if (v1 && !int_hold) begin
        integ <= int_next;
        isat  <= int_clamp;
      end else if (v1) begin
        isat  <= 1'b0;
      end

      // S3
      action_valid <= v2;
      if (v2) begin
        action <= out_next;
        sat    <= |flags;
      end
    end
  end

endmodule

// File: tb/tb_pi_servo.sv
// tb_pi_servo: randomized and directed bench for pi_servo (default build).
// The driver advances a transaction-level model of the loop filter and
// queues the expected action/sat/arrival cycle for each sample; a monitor
// on the falling edge pops and compares whenever action_valid is seen.
module tb_pi_servo;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic               err_valid = 1'b0;
  logic signed [15:0] err = '0;
  logic signed [17:0] kp = '0;
  logic signed [17:0] ki = '0;
  logic               int_clear = 1'b0;
  logic signed [31:0] action;
  logic               action_valid;
  logic               sat;

  always #5 clk = ~clk;

  pi_servo dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .err_valid   (err_valid),
    .err         (err),
    .kp          (kp),
    .ki          (ki),
    .int_clear   (int_clear),
`ifdef PI_SERVO_HOLD_EN
    .hold        (1'b0),
`endif
    .action      (action),
    .action_valid(action_valid),
    .sat         (sat)
  );

  typedef struct {
    longint act;
    bit     sat;
    int     cyc;
  } exp_t;

  typedef struct {
    int     kind;  // 0 action, 1 action_valid, 2 sat, 3 scoreboard depth
    longint expv;
    string  name;
  } probe_t;

  exp_t   exp_q[$];
  probe_t pr_q[$];

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  bit     verbose = 1'b1;
  bit     mono_en = 1'b0;
  longint last_act = 0;

  // Reference model state (loop-level, not pipeline-level).
  longint m_int = 0;
  bit     prev_v = 1'b0;
  longint prev_pp = 0;
  longint prev_ip = 0;
  bit     pushed_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint clampw(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t   e;
    probe_t p;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_output: no action_valid at cycle %0d (now %0d), expected action %0d",
               e.cyc, cyc, e.act);
    end
    if (!rst && action_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got action_valid with action %0d at cycle %0d, expected none",
                 action, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("action", longint'(action), e.act);
        chk("sat", longint'(sat), longint'(e.sat));
        chk("latency", longint'(cyc), longint'(e.cyc));
        if (mono_en) chk("monotonic_fall", longint'(longint'(action) <= last_act), 1);
        last_act = longint'(action);
        if (verbose)
          $display("[TB] cyc=%0d action=%0d sat=%0b", cyc, action, sat);
      end
    end
    while (pr_q.size() > 0) begin
      p = pr_q.pop_front();
      case (p.kind)
        0:       chk(p.name, longint'(action), p.expv);
        1:       chk(p.name, longint'(action_valid), p.expv);
        2:       chk(p.name, longint'(sat), p.expv);
        default: chk(p.name, longint'(exp_q.size()), p.expv);
      endcase
    end
  end

  task automatic probe(input int kind, input longint expv, input string name);
    pr_q.push_back('{kind: kind, expv: expv, name: name});
  endtask

  // Drive one clock worth of inputs and advance the model across that edge.
  // The sample issued on the previous call reaches its integrator update at
  // this edge, so its output is fully determined now and becomes visible
  // two edges later.
  task automatic step(input bit e, input bit v, input int er, input int kpv,
                      input int kiv, input bit clr);
    longint nxt, clp, sum, sh, o;
    bit     is;
    is = 1'b0;
    en = e; err_valid = v; err = 16'(er); kp = 18'(kpv); ki = 18'(kiv); int_clear = clr;
    if (!e) begin
      if (pushed_last) void'(exp_q.pop_back());
      m_int = 0; prev_v = 1'b0; pushed_last = 1'b0;
    end else begin
      pushed_last = 1'b0;
      if (clr) begin
        m_int = 0;
      end else if (prev_v) begin
        nxt   = m_int + prev_ip;
        clp   = clampw(nxt, 48);
        is    = (clp != nxt);
        m_int = clp;
      end
      if (prev_v) begin
        sum = prev_pp + m_int;
        sh  = sum >>> 16;
        o   = clampw(sh, 32);
        exp_q.push_back('{act: o, sat: is || (o != sh), cyc: cyc + 2});
        pushed_last = 1'b1;
      end
      prev_v  = v;
      prev_pp = longint'(er) * longint'(kpv);
      prev_ip = longint'(er) * longint'(kiv);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    exp_q.delete();
    m_int = 0; prev_v = 1'b0; pushed_last = 1'b0;
    probe(0, 0, "rst_action");
    probe(1, 0, "rst_action_valid");
    probe(2, 0, "rst_sat");
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int er, kpv, kiv, sc;
    probe(0, 0, "reset_action");
    probe(1, 0, "reset_action_valid");
    probe(2, 0, "reset_sat");
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Unity P gain, single sample.
    step(1, 1, 100, 65536, 0, 0);
    idle(4);
    // Floor shift on tiny products.
    step(1, 1, -1, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    idle(4);
    // Pure I path, back-to-back samples.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 65536, 0);
    idle(4);
    // Bring integrator to 5, then clear as a sample reaches the integrator.
    for (int i = 0; i < 2; i++) step(1, 1, 1, 0, 65536, 0);
    idle(3);
    step(1, 1, 1, 65536, 65536, 0);
    step(1, 0, 0, 0, 0, 1);
    idle(3);
    step(1, 1, 1, 0, 65536, 0);
    idle(4);
    // Loop opened one cycle after a valid sample.
    step(1, 1, 1000, 65536, 65536, 0);
    step(0, 0, 0, 0, 0, 0);
    probe(0, 0, "en_low_action");
    probe(1, 0, "en_low_action_valid");
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 1, 1, 0, 65536, 0);  // integrator must restart from 0
    idle(4);

    // Randomized traffic with occasional clears and loop drops.
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      sc  = int'($urandom_range(0, 3));
      er  = int'($urandom_range(0, 65535)) - 32768;
      kpv = (int'($urandom_range(0, 262143)) - 131072) >>> (sc * 4);
      kiv = (int'($urandom_range(0, 262143)) - 131072) >>> (sc * 4);
      step($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0, er, kpv, kiv,
           $urandom_range(0, 15) == 0);
    end
    step(1, 1, 20000, 100000, 0, 0);
    step(1, 1, -20000, 100000, 0, 0);
    mid_reset();
    idle(4);

    // Drive both rails: integrator stops at 2^47-1, action at 2^31-1.
    for (int i = 0; i < 32800; i++) step(1, 1, 32767, 131071, 131071, 0);
    idle(3);
    verbose = 1'b1;
    step(1, 1, 32767, 131071, 131071, 0);
    idle(3);
    mono_en = 1'b1;
    for (int i = 0; i < 40; i++) step(1, 1, -32767, 131071, 131071, 0);
    idle(4);
    mono_en = 1'b0;

    idle(4);
    probe(3, 0, "scoreboard_drained");
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
